// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - Shared gray/binary helpers and address-width derivation for async FIFO controllers
package fifo_pkg;

    function automatic int unsigned addr_width(int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic logic [31:0] bin2gray(logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rptr_empty_if.sv
// rtl/fifo_rptr_empty_if.sv - Read-side consumer/status bundle of the async FIFO
interface fifo_rptr_empty_if #(
    parameter int AW = 3
) ();
    logic          r_en;
    logic [AW:0]   rq2_wptr;
    logic          r_underflow_clr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          r_empty;
    logic          r_almost_empty;
    logic [AW:0]   r_count;
    logic          r_underflow;
    logic          r_valid;

    modport master (
        output r_en, rq2_wptr, r_underflow_clr,
        input  raddr, rptr, r_empty, r_almost_empty, r_count, r_underflow, r_valid
    );

    modport slave (
        input  r_en, rq2_wptr, r_underflow_clr,
        output raddr, rptr, r_empty, r_almost_empty, r_count, r_underflow, r_valid
    );
endinterface

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - Combinational gray-to-binary converter (prefix XOR from the MSB)
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end
endmodule

// File: rtl/fifo_rptr_empty.sv
// rtl/fifo_rptr_empty.sv - Read-domain pointer, empty/almost-empty, occupancy and underflow controller
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AE_THRESH = 1
) (
    input  logic               r_clk,
    input  logic               rst_n,
    fifo_rptr_empty_if.slave   rif
);
    localparam int AW = addr_width(DEPTH);
    localparam int PW = AW + 1;

    logic [AW:0] rbin_q, rbin_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count_q, count_d;
    logic [AW:0] wbin;
    logic        empty_q, empty_d;
    logic        aempty_q, aempty_d;
    logic        underflow_q, underflow_d;
    logic        valid_q, valid_d;
    logic        r_inc;

    fifo_gray2bin #(.W(PW)) u_gray2bin (
        .gray_i (rif.rq2_wptr),
        .bin_o  (wbin)
    );

    // Status is derived from the next pointer so empty asserts in the same
    // cycle the last read is registered, never one cycle late.
    always_comb begin
        r_inc       = rif.r_en & ~empty_q;
        rbin_d      = rbin_q + {{AW{1'b0}}, r_inc};
        rptr_d      = PW'(bin2gray(32'(rbin_d)));
        count_d     = wbin - rbin_d;
        empty_d     = (rptr_d == rif.rq2_wptr);
        aempty_d    = (count_d <= PW'(AE_THRESH));
        underflow_d = (rif.r_en & empty_q) | (underflow_q & ~rif.r_underflow_clr);
        valid_d     = r_inc;
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
            valid_q     <= valid_d;
        end
    end

    assign rif.raddr          = rbin_q[AW-1:0];
    assign rif.rptr           = rptr_q;
    assign rif.r_empty        = empty_q;
    assign rif.r_almost_empty = aempty_q;
    assign rif.r_count        = count_q;
    assign rif.r_underflow    = underflow_q;
    assign rif.r_valid        = valid_q;
endmodule
